multi_nibble_adder_ctrl: RTL and testbench

MULTI_NIBBLE_ADDER_CTRL -- requirements
Module: multi_nibble_adder_ctrl

---
 rtl/multi_nibble_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_multi_nibble_adder_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_nibble_adder_ctrl.sv
// Serial W-bit adder: one 4-bit adder slice is reused once per nibble, LSB first,
// with a carry register between nibbles. Results are held until the next accepted start.
module multi_nibble_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     a_q, b_q;
    logic             load;

    logic [3:0]       nib_a, nib_b;
    logic [4:0]       slice;
    logic             msb_cin;

    // The single shared 4-bit slice; msb_cin recovers the carry into the nibble's top bit.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
        slice   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        msb_cin = nib_a[3] ^ nib_b[3] ^ slice[3];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_ADD;
                    idx_d   = '0;
                    carry_d = cin;
                    load    = 1'b1;
                end
            end
            S_ADD: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[4*n +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[4];
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    cout_d  = slice[4];
                    ovf_d   = msb_cin ^ slice[4];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operands are captured only on acceptance, so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multi_nibble_adder_ctrl.sv
// Directed bench for multi_nibble_adder_ctrl (NIBBLES = 4); outputs sampled on the falling edge.
module tb_multi_nibble_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } vec_t;

    vec_t vecs [7] = '{
        '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0},
        '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
        '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1},
        '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}
    };

    multi_nibble_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl_async: busy/done=%b required 00", {busy, done});
        end
        n_cmp++;
        if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_data_async: cout=%b ovf=%b sum=%h required 0 0 0000", cout, ovf, sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b cout=%b ovf=%b sum=%h required all 0",
                     busy, done, cout, ovf, sum);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            end
            n_cmp++;
            if (busy !== ((k <= 4) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL basic_busy cycle %0d: busy=%b required %b", k, busy, (k <= 4));
            end
            n_cmp++;
            if (done !== ((k == 5) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL basic_done cycle %0d: done=%b required %b", k, done, (k == 5));
            end
            if (k >= 5) begin
                n_cmp++;
                if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h2345}) begin
                    n_fail++;
                    $display("FAIL basic_result cycle %0d: cout=%b ovf=%b sum=%h required 0 0 2345",
                             k, cout, ovf, sum);
                end
            end
        end
    endtask

    task automatic test_vectors();
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            a = vecs[v].a; b = vecs[v].b; cin = vecs[v].ci; start = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    start = 1'b0; a = ~a; b = 16'h5A5A; cin = ~cin;
                end
                n_cmp++;
                if (done !== ((k == 5) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL vec%0d_done cycle %0d: done=%b required %b", v, k, done, (k == 5));
                end
            end
            n_cmp++;
            if ({cout, ovf, sum} !== {vecs[v].co, vecs[v].v, vecs[v].s}) begin
                n_fail++;
                $display("FAIL vec%0d_result: cout=%b ovf=%b sum=%h required %b %b %h",
                         v, cout, ovf, sum, vecs[v].co, vecs[v].v, vecs[v].s);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_s;
        logic         exp_co, exp_v;
        for (int m = 0; m <= 15; m++) begin
            @(negedge clk);
            if (m > 0) begin
                n_cmp++;
                if (busy !== ((m % 5 != 0) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_busy cycle %0d: busy=%b required %b", m, busy, (m % 5 != 0));
                end
                n_cmp++;
                if (done !== ((m % 5 == 0) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_done cycle %0d: done=%b required %b", m, done, (m % 5 == 0));
                end
                if (m % 5 == 0) begin
                    if (m == 5) begin
                        exp_s = 16'h0407; exp_co = 1'b0; exp_v = 1'b0;
                    end else if (m == 10) begin
                        exp_s = 16'h8000; exp_co = 1'b0; exp_v = 1'b1;
                    end else begin
                        exp_s = 16'h0011; exp_co = 1'b1; exp_v = 1'b0;
                    end
                    n_cmp++;
                    if ({cout, ovf, sum} !== {exp_co, exp_v, exp_s}) begin
                        n_fail++;
                        $display("FAIL b2b_result cycle %0d: cout=%b ovf=%b sum=%h required %b %b %h",
                                 m, cout, ovf, sum, exp_co, exp_v, exp_s);
                    end
                end
            end
            if (m == 0) begin
                a = 16'h0102; b = 16'h0304; cin = 1'b1;
            end else if (m == 5) begin
                a = 16'h7000; b = 16'h1000; cin = 1'b0;
            end else if (m == 10) begin
                a = 16'hF00F; b = 16'h1001; cin = 1'b1;
            end else begin
                a = 16'hF000 | 16'(m); b = 16'h0F0F ^ 16'(m * 257); cin = m[0];
            end
            start = (m < 15) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: busy=%b done=%b cout=%b ovf=%b sum=%h required all 0",
                     busy, done, cout, ovf, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL midrst_no_done cycle %0d: busy/done=%b required 00", k, {busy, done});
            end
        end
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if ({busy, done} !== ((k == 5) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL midrst_restart_ctrl cycle %0d: busy/done=%b required %b",
                         k, {busy, done}, ((k == 5) ? 2'b01 : 2'b10));
            end
        end
        n_cmp++;
        if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h3333}) begin
            n_fail++;
            $display("FAIL midrst_restart_result: cout=%b ovf=%b sum=%h required 0 0 3333", cout, ovf, sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
